// File: rtl/mem_fill_engine.sv
// mem_fill_engine: writes LEN generated words into a single-port RAM
// starting at a base address, with stall back-pressure and abort.
module mem_fill_engine #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_value,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              stall,
   input  logic              abort,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] M_ID    = 2'd0;
   localparam logic [1:0] M_CONST = 2'd1;
   localparam logic [1:0] M_UP    = 2'd2;
   localparam logic [1:0] M_DN    = 2'd3;

   state_t            state;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] fill_q;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx;
   logic [DATA_W-1:0] idx_d;
   logic [DATA_W-1:0] data_c;
   logic              run;
   logic              last;

   assign run   = (state == RUN);
   assign idx_d = DATA_W'(idx);
   assign last  = (idx == len_q - LEN_W'(1));

   // data generator selected by the latched mode, modulo 2^DATA_W
   always_comb begin
      data_c = fill_q;
      case (mode_q)
         M_ID:    data_c = idx_d;
         M_CONST: data_c = fill_q;
         M_UP:    data_c = fill_q + idx_d;
         M_DN:    data_c = fill_q - idx_d;
         default: data_c = fill_q;
      endcase
   end

   assign wr_en   = run && !stall && !abort;
   assign wr_addr = run ? base_q + ADDR_W'(idx) : '0;
   assign wr_data = run ? data_c : '0;

   // control FSM with registered busy/done
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mode_q <= '0;
         fill_q <= '0;
         base_q <= '0;
         len_q  <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  fill_q <= fill_value;
                  base_q <= base_addr;
                  len_q  <= len;
                  idx    <= '0;
                  if (len != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (!stall) begin
                  idx <= idx + LEN_W'(1);
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fill_engine.sv
// tb_mem_fill_engine: directed fills checked cycle by cycle against
// a transaction-level expectation queue, plus literal write-log checks.
module tb_mem_fill_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] fill_value = '0;
   logic [7:0] base_addr = '0;
   logic [8:0] len = '0;
   logic       stall = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       busy;
   logic       done;

   mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .fill_value(fill_value), .base_addr(base_addr), .len(len),
      .stall(stall), .abort(abort), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t        expq[$];
   exp_t        cur;
   logic [15:0] logq[$];
   int          busy_cnt = 0;
   int          done_cnt = 0;
   int          total = 0;
   int          bad = 0;

   logic [1:0] nx_mode;
   logic [7:0] nx_fv;
   logic [7:0] nx_base;
   logic [8:0] nx_len;

   function automatic logic [7:0] mdl_data(logic [1:0] m, logic [7:0] fv,
                                           int k);
      case (m)
         2'd0:    return 8'(k);
         2'd1:    return fv;
         2'd2:    return fv + 8'(k);
         default: return fv - 8'(k);
      endcase
   endfunction

   function automatic exp_t e_idle();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t e_run(logic [7:0] a, logic [7:0] d, logic we);
      exp_t e;
      e = '0;
      e.busy = 1'b1;
      e.we = we;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   function automatic exp_t e_done();
      exp_t e;
      e = '0;
      e.done = 1'b1;
      return e;
   endfunction

   // per-cycle compare against the expectation queue, and write logging
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         cur = expq.pop_front();
         total++;
         if ({busy, done, wr_en, wr_addr, wr_data} !== cur) begin
            bad++;
            $display("FAIL cycle t=%0t got b/d/we/a/d=%b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                     $time, busy, done, wr_en, wr_addr, wr_data,
                     cur.busy, cur.done, cur.we, cur.addr, cur.data);
         end
         if (wr_en === 1'b1) logq.push_back({wr_addr, wr_data});
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic step(input logic st, input logic ab, input logic sr,
                       input logic rs, input exp_t e);
      @(posedge clk);
      #1;
      stall = st;
      abort = ab;
      reset = rs;
      start = sr;
      if (sr) begin
         mode = nx_mode;
         fill_value = nx_fv;
         base_addr = nx_base;
         len = nx_len;
      end else begin
         mode = 2'($urandom);
         fill_value = 8'($urandom);
         base_addr = 8'($urandom);
         len = 9'($urandom);
      end
      expq.push_back(e);
   endtask

   task automatic fill(input logic [1:0] m, input logic [7:0] fv,
                       input logic [7:0] b, input int n,
                       input int stall_at, input int stall_n,
                       input int abort_at, input int reset_at,
                       input bit sid);
      int k;
      int s;
      bit cut;
      logic [7:0] a;
      logic [7:0] d;
      logq.delete();
      busy_cnt = 0;
      done_cnt = 0;
      nx_mode = m;
      nx_fv = fv;
      nx_base = b;
      nx_len = 9'(n);
      step(1'b0, 1'b0, 1'b1, 1'b0, e_idle());
      k = 0;
      s = 0;
      cut = 1'b0;
      while (k < n && !cut) begin
         a = b + 8'(k);
         d = mdl_data(m, fv, k);
         if (k == abort_at) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, e_run(a, d, 1'b0));
            cut = 1'b1;
         end else if (k == reset_at) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, e_run(a, d, 1'b1));
            cut = 1'b1;
         end else if (k == stall_at && s < stall_n) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, e_run(a, d, 1'b0));
            s++;
         end else begin
            step(1'b0, 1'b0, 1'b0, 1'b0, e_run(a, d, 1'b1));
            k++;
         end
      end
      if (!cut) begin
         if (sid) begin
            nx_mode = 2'd1;
            nx_len = 9'd4;
         end
         step(1'b0, 1'b0, sid, 1'b0, e_done());
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, e_idle());
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic chk_log(input string nm, input logic [15:0] want[$]);
      int first;
      chk({nm, "_n"}, logq.size(), want.size());
      first = -1;
      for (int i = 0; i < want.size() && i < logq.size(); i++)
         if (first < 0 && logq[i] !== want[i]) first = i;
      total++;
      if (first >= 0) begin
         bad++;
         $display("FAIL %s entry %0d got=%h want=%h",
                  nm, first, logq[first], want[first]);
      end
   endtask

   initial begin
      logic [15:0] w[$];
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 1'b1, e_idle());
      step(1'b0, 1'b0, 1'b0, 1'b0, e_idle());
      step(1'b0, 1'b0, 1'b0, 1'b0, e_idle());

      // full identity sweep
      fill(2'd0, 8'h00, 8'h00, 256, -1, 0, -1, -1, 1'b0);
      w.delete();
      for (int k = 0; k < 256; k++) w.push_back({8'(k), 8'(k)});
      chk_log("t1_log", w);
      chk("t1_busy", busy_cnt, 256);
      chk("t1_done", done_cnt, 1);

      // constant with address wrap
      fill(2'd1, 8'hA5, 8'hFE, 4, -1, 0, -1, -1, 1'b0);
      w = '{16'hFEA5, 16'hFFA5, 16'h00A5, 16'h01A5};
      chk_log("t2_log", w);

      // ramps with data wrap
      fill(2'd2, 8'hFE, 8'h10, 3, -1, 0, -1, -1, 1'b0);
      w = '{16'h10FE, 16'h11FF, 16'h1200};
      chk_log("t3_up", w);
      fill(2'd3, 8'h01, 8'h20, 3, -1, 0, -1, -1, 1'b0);
      w = '{16'h2001, 16'h2100, 16'h22FF};
      chk_log("t3_dn", w);

      // stall for three cycles at idx 2
      fill(2'd0, 8'h00, 8'h40, 8, 2, 3, -1, -1, 1'b0);
      w = '{16'h4000, 16'h4101, 16'h4202, 16'h4303,
            16'h4404, 16'h4505, 16'h4606, 16'h4707};
      chk_log("t4_log", w);
      chk("t4_busy", busy_cnt, 11);
      chk("t4_done", done_cnt, 1);

      // zero length, start during DONE ignored
      fill(2'd2, 8'h33, 8'h00, 0, -1, 0, -1, -1, 1'b1);
      chk("t5_writes", logq.size(), 0);
      chk("t5_busy", busy_cnt, 0);
      chk("t5_done", done_cnt, 1);

      // abort at idx 5, then a normal restart
      fill(2'd1, 8'h77, 8'h80, 16, -1, 0, 5, -1, 1'b0);
      chk("t6_writes", logq.size(), 5);
      chk("t6_busy", busy_cnt, 6);
      chk("t6_done", done_cnt, 0);
      fill(2'd3, 8'h10, 8'h90, 6, -1, 0, -1, -1, 1'b0);
      w = '{16'h9010, 16'h910F, 16'h920E, 16'h930D, 16'h940C, 16'h950B};
      chk_log("t6_restart", w);
      chk("t6r_done", done_cnt, 1);

      // reset asserted at idx 10
      fill(2'd0, 8'h00, 8'hF8, 16, -1, 0, -1, 10, 1'b0);
      chk("t7_writes", logq.size(), 11);
      chk("t7_busy", busy_cnt, 11);
      chk("t7_done", done_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_fill_engine.md
Name: mem_fill_engine

Overview:
Parametrised memory initialiser: on a start request, writes LEN consecutive words into a single-port RAM, beginning at a programmable base address. Four data-generation modes are supported: identity (S-array style i -> i), constant, ascending ramp and descending ramp. A stall input provides back-pressure, and an abort input cancels a fill mid-run. The block drives the RAM write port directly and reports busy and done to the top-level controller FSM. It serves RC4 S-array setup and general buffer clearing.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, RAM data width
LEN_W, ADDR_W+1, width of the length field; must be able to express 2^ADDR_W

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  request; sampled only in IDLE
mode  in  2  0 IDENTITY, 1 CONSTANT, 2 RAMP_UP, 3 RAMP_DOWN; latched on start
fill_value  in  DATA_W  constant or seed value; latched on start
base_addr  in  ADDR_W  first write address; latched on start
len  in  LEN_W  number of words to write; latched on start
stall  in  1  RAM not ready; holds the current write
abort  in  1  cancel the fill in progress
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
wr_en  out  1  RAM write strobe; one word per cycle with wr_en=1
busy  out  1  high while in RUN
done  out  1  one-cycle pulse after the last write of a completed fill

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset forces IDLE. Reset also clears the index and latched registers and sets all outputs to 0.
- IDLE: busy=0, wr_en=0.
  - On start=1: latch mode, fill_value, base_addr and len; set idx=0.
  - If len!=0, go to RUN. If len==0, go to DONE, so no write is issued and done still pulses.
- RUN: busy=1.
  - wr_addr = (base_addr + idx) mod 2^ADDR_W.
  - wr_en = !stall && !abort, combinational from the registered state and the inputs.
  - wr_data depends on the latched mode, with all arithmetic modulo 2^DATA_W:
    - IDENTITY: idx[DATA_W-1:0]
    - CONSTANT: fill_value
    - RAMP_UP: fill_value + idx
    - RAMP_DOWN: fill_value - idx
  - stall=1: idx, wr_addr and wr_data hold; no write is issued.
  - stall=0 and abort=0: one write is issued; idx increments. If idx==len-1, go to DONE.
  - abort=1: go to IDLE next cycle; no write that cycle; done is not pulsed. abort has priority over stall.
- DONE: done=1, busy=0, wr_en=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start, abort and stall are ignored in IDLE when not relevant. start is ignored while in RUN, and the latched values do not change during RUN.
- Latency with no stall: start sampled at edge N gives wr_en high for cycles N+1 .. N+len, done high in cycle N+len+1. The earliest accepted restart is a start sampled at edge N+len+2.
- Each stalled cycle extends the run by exactly one cycle. No write is lost or duplicated.
- idx width is LEN_W. len = 2^ADDR_W writes every address exactly once; wr_addr wraps from 2^ADDR_W-1 to 0. For len > 2^ADDR_W, addresses wrap and later writes overwrite earlier ones; this is legal.
- IDENTITY with DATA_W < LEN_W writes the truncated low bits of idx.
- Reset asserted during RUN or DONE: IDLE on the next edge, all outputs 0, no done pulse.
- mode, fill_value, base_addr and len are don't-care outside the start cycle.

Test Plan:
- Defaults, start with mode=0, base=0x00, len=256, stall=0 -> 256 consecutive wr_en cycles writing addr k with data k (k=0..255); done pulses once at cycle 257 after start; busy high for exactly 256 cycles.
- mode=1, fill_value=0xA5, base=0xFE, len=4 -> writes to 0xFE, 0xFF, 0x00, 0x01, all with data 0xA5 (address wrap).
- mode=2, fill_value=0xFE, len=3 -> data 0xFE, 0xFF, 0x00. mode=3, fill_value=0x01, len=3 -> data 0x01, 0x00, 0xFF (data wrap).
- mode=0, len=8, stall asserted for 3 cycles at idx=2 -> wr_addr/wr_data frozen at idx 2 with wr_en=0; exactly 8 writes total; done at cycle 8+3+1 after start.
- len=0 -> no wr_en; busy stays 0; done pulses one cycle after start. A start during the DONE cycle is ignored.
- abort at idx=5 of len=16 -> no write that cycle; IDLE next cycle with no done; a subsequent start re-latches and runs normally. Reset asserted at idx=10 -> all outputs 0 on the next edge.
